// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: bubble word, opcodes, fetch FSM
// states and small RV32I instruction-format encoders.
package riscv_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_ALIGNED = 2'd0,
    ST_HALF    = 2'd1,
    ST_REALIGN = 2'd2
  } fstate_e;

  function automatic logic [31:0] enc_i(
    logic [11:0] imm, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    logic [11:0] imm, logic [4:0] rs2,
    logic [4:0] rs1, logic [2:0] f3, logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(
    logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(
    logic [12:0] imm, logic [4:0] rs2,
    logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(
    logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(
    logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11],
            imm[19:12], rd, OP_JAL};
  endfunction

endpackage

// File: rtl/rvc_expander.sv
// RV32C -> RV32I combinational expander (C0/C1/C2 integer subset).
// Ports: in[15:0] halfword, out[31:0] expansion, illegal flag. Built with RVC_EN.
`ifdef RVC_EN
module rvc_expander
  import riscv_pkg::*;
(
  input  logic [15:0] in,
  output logic [31:0] out,
  output logic        illegal
);

  logic [4:0]  rd, rs2, rs1p, rs2p;
  logic [11:0] imm6;
  logic [20:0] jimm;
  logic [12:0] bimm;

  assign rd   = in[11:7];
  assign rs2  = in[6:2];
  assign rs1p = {2'b01, in[9:7]};
  assign rs2p = {2'b01, in[4:2]};
  assign imm6 = {{6{in[12]}}, in[12], in[6:2]};
  assign jimm = {{9{in[12]}}, in[12], in[8], in[10:9],
                 in[6], in[7], in[2], in[11], in[5:3], 1'b0};
  assign bimm = {{4{in[12]}}, in[12], in[6:5], in[2],
                 in[11:10], in[4:3], 1'b0};

  always_comb begin
    out     = NOP_INST;
    illegal = 1'b0;
    unique case ({in[1:0], in[15:13]})
      5'b00_000: begin
        if (in[12:5] == 8'd0) illegal = 1'b1;
        else out = enc_i({2'b0, in[10:7], in[12:11], in[5],
                          in[6], 2'b00}, 5'd2, 3'b000, rs2p,
                         OP_OPIMM);
      end
      5'b00_010:
        out = enc_i({5'b0, in[5], in[12:10], in[6], 2'b00},
                    rs1p, 3'b010, rs2p, OP_LOAD);
      5'b00_110:
        out = enc_s({5'b0, in[5], in[12:10], in[6], 2'b00},
                    rs2p, rs1p, 3'b010, OP_STORE);
      5'b01_000: out = enc_i(imm6, rd, 3'b000, rd, OP_OPIMM);
      5'b01_001: out = enc_j(jimm, 5'd1);
      5'b01_010: out = enc_i(imm6, 5'd0, 3'b000, rd, OP_OPIMM);
      5'b01_011: begin
        if ({in[12], in[6:2]} == 6'd0) illegal = 1'b1;
        else if (rd == 5'd2)
          out = enc_i({{2{in[12]}}, in[12], in[4:3], in[5],
                       in[2], in[6], 4'b0}, 5'd2, 3'b000,
                      5'd2, OP_OPIMM);
        else
          out = enc_u({{14{in[12]}}, in[12], in[6:2]},
                      rd, OP_LUI);
      end
      5'b01_100: begin
        unique case (in[11:10])
          2'b00: begin
            if (in[12]) illegal = 1'b1;
            else out = enc_r(7'b0000000, rs2, rs1p, 3'b101,
                             rs1p, OP_OPIMM);
          end
          2'b01: begin
            if (in[12]) illegal = 1'b1;
            else out = enc_r(7'b0100000, rs2, rs1p, 3'b101,
                             rs1p, OP_OPIMM);
          end
          2'b10:
            out = enc_i(imm6, rs1p, 3'b111, rs1p, OP_OPIMM);
          default: begin
            if (in[12]) illegal = 1'b1;
            else begin
              unique case (in[6:5])
                2'b00: out = enc_r(7'b0100000, rs2p, rs1p,
                                   3'b000, rs1p, OP_OP);
                2'b01: out = enc_r(7'b0, rs2p, rs1p,
                                   3'b100, rs1p, OP_OP);
                2'b10: out = enc_r(7'b0, rs2p, rs1p,
                                   3'b110, rs1p, OP_OP);
                default: out = enc_r(7'b0, rs2p, rs1p,
                                     3'b111, rs1p, OP_OP);
              endcase
            end
          end
        endcase
      end
      5'b01_101: out = enc_j(jimm, 5'd0);
      5'b01_110: out = enc_b(bimm, 5'd0, rs1p, 3'b000);
      5'b01_111: out = enc_b(bimm, 5'd0, rs1p, 3'b001);
      5'b10_000: begin
        if (in[12]) illegal = 1'b1;
        else out = enc_r(7'b0, rs2, rd, 3'b001, rd, OP_OPIMM);
      end
      5'b10_010: begin
        if (rd == 5'd0) illegal = 1'b1;
        else out = enc_i({4'b0, in[3:2], in[12], in[6:4],
                          2'b00}, 5'd2, 3'b010, rd, OP_LOAD);
      end
      5'b10_100: begin
        if (!in[12]) begin
          if (rs2 != 5'd0)
            out = enc_r(7'b0, rs2, 5'd0, 3'b000, rd, OP_OP);
          else if (rd == 5'd0) illegal = 1'b1;
          else out = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
        end else begin
          if (rs2 != 5'd0)
            out = enc_r(7'b0, rs2, rd, 3'b000, rd, OP_OP);
          else if (rd == 5'd0)
            out = enc_i(12'd1, 5'd0, 3'b000, 5'd0, OP_SYSTEM);
          else out = enc_i(12'd0, rd, 3'b000, 5'd1, OP_JALR);
        end
      end
      5'b10_110:
        out = enc_s({4'b0, in[8:7], in[12:9], 2'b00},
                    rs2, 5'd2, 3'b010, OP_STORE);
      default: illegal = 1'b1;
    endcase
    if (illegal) out = NOP_INST;
  end

endmodule
`endif

// File: rtl/riscv_if.sv
// RV32 instruction fetch stage with optional RVC realignment (macro RVC_EN)
// and static backward-taken branch prediction. Ports: clk, rst_n (sync),
// stall, flush, redirect_pc -> icache_ren/addr/rdata/stall -> IF/ID *_ppl.
module riscv_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        icache_ren,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  output logic [31:0] inst_ppl,
  output logic [31:0] pc_ppl,
  output logic        compressed_ppl,
  output logic        branch_taken_ppl
);
  import riscv_pkg::*;

  fstate_e     state, nxt_state;
  logic [31:1] pc_r, nxt_pc, tgt;
  logic [31:0] emit_inst;
  logic [1:0]  step;
  logic        emit, emit_comp, take;
  logic        unused_ok;

  assign unused_ok  = redirect_pc[0];
  assign icache_ren = rst_n;
  // HALF already owns the low halfword; fetch the following word
  assign icache_addr = (state == ST_HALF) ?
                       pc_r[31:2] + 30'd1 : pc_r[31:2];

`ifdef RVC_EN
  logic [15:0] hold_r, nxt_hold, half;
  logic [31:0] exp_inst, rvc_inst;
  logic        exp_ill;

  assign half = (state == ST_HALF) ? hold_r : icache_rdata[15:0];

  rvc_expander u_rvc (
    .in      (half),
    .out     (exp_inst),
    .illegal (exp_ill)
  );

  assign rvc_inst = exp_ill ? NOP_INST : exp_inst;
`endif

  always_comb begin
    nxt_state = state;
    emit      = 1'b0;
    emit_comp = 1'b0;
    emit_inst = NOP_INST;
    step      = 2'd0;
`ifdef RVC_EN
    nxt_hold  = hold_r;
    unique case (state)
      ST_ALIGNED: if (!icache_stall) begin
        emit = 1'b1;
        if (icache_rdata[1:0] != 2'b11) begin
          emit_inst = rvc_inst;
          emit_comp = 1'b1;
          nxt_hold  = icache_rdata[31:16];
          step      = 2'd1;
          nxt_state = ST_HALF;
        end else begin
          emit_inst = icache_rdata;
          step      = 2'd2;
        end
      end
      ST_HALF: begin
        // a buffered RVC op needs no new word
        if (hold_r[1:0] != 2'b11) begin
          emit      = 1'b1;
          emit_inst = rvc_inst;
          emit_comp = 1'b1;
          step      = 2'd1;
          nxt_state = ST_ALIGNED;
        end else if (!icache_stall) begin
          emit      = 1'b1;
          emit_inst = {icache_rdata[15:0], hold_r};
          nxt_hold  = icache_rdata[31:16];
          step      = 2'd2;
        end
      end
      ST_REALIGN: if (!icache_stall) begin
        nxt_hold  = icache_rdata[31:16];
        nxt_state = ST_HALF;
      end
      default: nxt_state = ST_ALIGNED;
    endcase
`else
    if (!icache_stall) begin
      emit      = 1'b1;
      emit_inst = icache_rdata;
      step      = 2'd2;
    end
`endif
    take = emit && (emit_inst[6:0] == OP_BRANCH) &&
           emit_inst[31];
    // B-immediate bits [31:1] added to halfword-granular pc
    tgt  = pc_r + {{19{emit_inst[31]}}, emit_inst[31],
                   emit_inst[7], emit_inst[30:25],
                   emit_inst[11:8]};
    nxt_pc = take ? tgt : pc_r + {29'd0, step};
    if (take) begin
`ifdef RVC_EN
      nxt_state = tgt[1] ? ST_REALIGN : ST_ALIGNED;
      nxt_hold  = '0;
`else
      nxt_state = ST_ALIGNED;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_ALIGNED;
      pc_r             <= RESET_PC[31:1];
      inst_ppl         <= NOP_INST;
      pc_ppl           <= '0;
      compressed_ppl   <= 1'b0;
      branch_taken_ppl <= 1'b0;
    end else if (flush) begin
      pc_r             <= redirect_pc[31:1];
`ifdef RVC_EN
      state            <= redirect_pc[1] ? ST_REALIGN
                                         : ST_ALIGNED;
`else
      state            <= ST_ALIGNED;
`endif
      inst_ppl         <= NOP_INST;
      compressed_ppl   <= 1'b0;
      branch_taken_ppl <= 1'b0;
    end else if (!stall) begin
      state            <= nxt_state;
      pc_r             <= nxt_pc;
      inst_ppl         <= emit ? emit_inst : NOP_INST;
      pc_ppl           <= {pc_r, 1'b0};
      compressed_ppl   <= emit & emit_comp;
      branch_taken_ppl <= take;
    end
  end

`ifdef RVC_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       hold_r <= '0;
    else if (flush)   hold_r <= '0;
    else if (!stall)  hold_r <= nxt_hold;
  end
`endif

endmodule
